multiplexer_seq: RTL and testbench

MULTIPLEXER_SEQ -- requirements
Module: multiplexer_seq

---
 rtl/pad_mux_pkg.sv | 29 ++
 rtl/multiplexer_seq_if.sv | 18 +
 rtl/multiplexer_seq_sel_debounce.sv | 42 ++++
 rtl/multiplexer_seq.sv | 144 ++++++++++++++
 tb/tb_multiplexer_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pad_mux_pkg.sv
// Shared types and default timing for the pad multiplexer.
// State encoding and sizing helpers live here.
package pad_mux_pkg;

  typedef enum logic [1:0] {
    PARK,
    GUARD,
    HOLD,
    RUN
  } state_t;

  localparam int DEF_N_PADS       = 42;
  localparam int DEF_N_DESIGNS    = 16;
  localparam int DEF_SEL_W        = 5;
  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_GUARD_CYC    = 8;
  localparam int DEF_HOLD_CYC     = 16;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/multiplexer_seq_if.sv
// Debounced design-select request bundle.
// Producer is the debouncer, consumer the switch FSM.
interface multiplexer_seq_if #(
  parameter int SEL_W = 5
);
  logic             req_valid;
  logic [SEL_W-1:0] req_sel;

  modport master (
    output req_valid,
    output req_sel
  );

  modport slave (
    input req_valid,
    input req_sel
  );
endinterface

// File: rtl/multiplexer_seq_sel_debounce.sv
// Synchronises design_sel and flags it once stable.
// req_valid stays high while the synced value holds.
module sel_debounce
  import pad_mux_pkg::*;
#(
  parameter int SEL_W        = DEF_SEL_W,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [SEL_W-1:0] design_sel,
  multiplexer_seq_if.master req
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC);

  logic [SEL_W-1:0] sync_a;
  logic [SEL_W-1:0] sel_s;
  logic [DW-1:0]    stable;

  // Two-flop sync, then count cycles sel_s is unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_a <= '0;
      sel_s  <= '0;
      stable <= '0;
    end else begin
      sync_a <= design_sel;
      sel_s  <= sync_a;
      if (sync_a != sel_s) begin
        stable <= '0;
      end else if (stable != D_LAST) begin
        stable <= stable + 1'b1;
      end
    end
  end

  assign req.req_valid = (stable == D_LAST);
  assign req.req_sel   = sel_s;

endmodule

// File: rtl/multiplexer_seq.sv
// Pad multiplexer: switches pads between designs safely.
// Parks pads, then holds the new design in reset.
module multiplexer_seq
  import pad_mux_pkg::*;
#(
  parameter int N_PADS       = DEF_N_PADS,
  parameter int N_DESIGNS    = DEF_N_DESIGNS,
  parameter int SEL_W        = DEF_SEL_W,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int GUARD_CYC    = DEF_GUARD_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [SEL_W-1:0]            design_sel,
  input  logic [N_DESIGNS*N_PADS-1:0] des_out,
  input  logic [N_DESIGNS*N_PADS-1:0] des_oe,
  input  logic [N_DESIGNS*N_PADS-1:0] des_pu,
  input  logic [N_DESIGNS*N_PADS-1:0] des_pd,
  input  logic [N_DESIGNS*N_PADS-1:0] des_cs,
  output logic [N_PADS-1:0]           io_out,
  output logic [N_PADS-1:0]           io_oe,
  output logic [N_PADS-1:0]           io_ie,
  output logic [N_PADS-1:0]           io_pu,
  output logic [N_PADS-1:0]           io_pd,
  output logic [N_PADS-1:0]           io_cs,
  output logic [N_DESIGNS-1:0]        rst_override_n,
  output logic [SEL_W-1:0]            active_sel,
  output logic                        busy
);

  localparam int CMAX = max3(GUARD_CYC, HOLD_CYC, DEBOUNCE_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYC - 1);
  localparam logic [SEL_W:0] ND = (SEL_W + 1)'(N_DESIGNS);

  multiplexer_seq_if #(.SEL_W(SEL_W)) req ();

  sel_debounce #(
    .SEL_W       (SEL_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .design_sel(design_sel),
    .req       (req)
  );

  state_t           state, state_nxt;
  logic [SEL_W-1:0] target, target_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             new_req;
  logic             tgt_ok;
  logic             pads_on;
  logic [SEL_W-1:0] idx;
  int               base;

  assign new_req = req.req_valid && (req.req_sel != target);
  assign tgt_ok  = {1'b0, target} < ND;

  // State, target and phase counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= PARK;
      target <= '1;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Next state: any new request restarts the guard phase.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    cnt_nxt    = cnt;
    unique case (state)
      PARK, RUN: begin
        if (new_req) begin
          target_nxt = req.req_sel;
          cnt_nxt    = '0;
          state_nxt  = GUARD;
        end
      end
      GUARD: begin
        if (new_req) begin
          target_nxt = req.req_sel;
          cnt_nxt    = '0;
        end else if (cnt == G_LAST) begin
          cnt_nxt   = '0;
          state_nxt = tgt_ok ? HOLD : PARK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (new_req) begin
          target_nxt = req.req_sel;
          cnt_nxt    = '0;
          state_nxt  = GUARD;
        end else if (cnt == H_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = PARK;
      end
    endcase
  end

  // Pads follow the target slice only once it is connected.
  always_comb begin
    idx            = tgt_ok ? target : '0;
    base           = int'(idx) * N_PADS;
    pads_on        = (state == HOLD) || (state == RUN);
    io_out         = '0;
    io_oe          = '0;
    io_pu          = '0;
    io_pd          = '0;
    io_cs          = '0;
    rst_override_n = '0;
    if (pads_on) begin
      io_out = des_out[base +: N_PADS];
      io_oe  = des_oe[base +: N_PADS];
      io_pu  = des_pu[base +: N_PADS];
      io_pd  = des_pd[base +: N_PADS];
      io_cs  = des_cs[base +: N_PADS];
    end
    if (state == RUN && tgt_ok) begin
      rst_override_n[idx] = 1'b1;
    end
  end

  assign io_ie      = ~io_oe;
  assign active_sel = target;
  assign busy       = (state != RUN);

endmodule

// File: tb/tb_multiplexer_seq.sv
// Bench for multiplexer_seq: queued phase expectations
// checked by a monitor on every state/target change.
module tb_multiplexer_seq;
  import pad_mux_pkg::*;

  localparam int NP = 42;
  localparam int ND = 16;
  localparam int SW = 5;
  localparam int DW = ND * NP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] design_sel;
  logic [DW-1:0] des_out, des_oe, des_pu, des_pd, des_cs;
  logic [NP-1:0] io_out, io_oe, io_ie, io_pu, io_pd, io_cs;
  logic [ND-1:0] rst_ovr;
  logic [SW-1:0] active_sel;
  logic          busy;

  always #5 clk = ~clk;

  multiplexer_seq #(
    .N_PADS      (NP),
    .N_DESIGNS   (ND),
    .SEL_W       (SW),
    .DEBOUNCE_CYC(4),
    .GUARD_CYC   (8),
    .HOLD_CYC    (16)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .design_sel    (design_sel),
    .des_out       (des_out),
    .des_oe        (des_oe),
    .des_pu        (des_pu),
    .des_pd        (des_pd),
    .des_cs        (des_cs),
    .io_out        (io_out),
    .io_oe         (io_oe),
    .io_ie         (io_ie),
    .io_pu         (io_pu),
    .io_pd         (io_pd),
    .io_cs         (io_cs),
    .rst_override_n(rst_ovr),
    .active_sel    (active_sel),
    .busy          (busy)
  );

  typedef struct {
    state_t        st;
    logic [SW-1:0] tgt;
    int            len;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;

  task automatic check(
    input string        name,
    input logic [255:0] act,
    input logic [255:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] slice(
    input logic [DW-1:0] v,
    input logic [SW-1:0] d
  );
    return v[int'(d)*NP +: NP];
  endfunction

  task automatic check_phase(
    input state_t        st,
    input logic [SW-1:0] tgt,
    input string         tag
  );
    bit            on;
    logic [NP-1:0] e_out, e_oe, e_pu, e_pd, e_cs;
    logic [ND-1:0] e_rst;
    on    = (st == HOLD) || (st == RUN);
    e_out = on ? slice(des_out, tgt) : '0;
    e_oe  = on ? slice(des_oe, tgt) : '0;
    e_pu  = on ? slice(des_pu, tgt) : '0;
    e_pd  = on ? slice(des_pd, tgt) : '0;
    e_cs  = on ? slice(des_cs, tgt) : '0;
    e_rst = '0;
    if (st == RUN) e_rst[tgt] = 1'b1;
    check({tag, "_rst"}, rst_ovr, e_rst);
    check({tag, "_busy"}, busy, (st != RUN));
    check({tag, "_sel"}, active_sel, tgt);
    check({tag, "_pads"},
          {io_out, io_oe, io_ie, io_pu, io_pd, io_cs},
          {e_out, e_oe, ~e_oe, e_pu, e_pd, e_cs});
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d phases pending, want 0",
               tag, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : monitor
    state_t        last_st;
    logic [SW-1:0] last_tgt;
    int            len;
    exp_t          e;
    wait (mon_en);
    @(negedge clk);
    last_st  = dut.state;
    last_tgt = active_sel;
    len      = 1;
    forever begin
      @(negedge clk);
      if (dut.state != last_st || active_sel != last_tgt) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_phase: got %s sel %0d want none",
                   dut.state.name(), active_sel);
        end else begin
          e = q.pop_front();
          check("phase", {dut.state, active_sel}, {e.st, e.tgt});
          if (e.len != 0) check("phase_len", len, e.len);
          check_phase(e.st, e.tgt, "entry");
        end
        last_st  = dut.state;
        last_tgt = active_sel;
        len      = 1;
      end else begin
        len++;
      end
    end
  end

  initial begin : stim
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < NP; p++) begin
        des_out[d*NP+p] = ((p + d) % 3) == 0;
        des_oe[d*NP+p]  = ((p + d) % 2) == 0;
        des_pu[d*NP+p]  = (p % (d + 2)) == 0;
        des_pd[d*NP+p]  = ((p + 2*d) % 5) == 0;
        des_cs[d*NP+p]  = (((p >> 1) + d) % 3) == 0;
      end
    end
    design_sel = 5'd3;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", dut.state, PARK);
    check_phase(PARK, 5'h1f, "reset");

    q.push_back('{GUARD, 5'd3, 0});
    q.push_back('{HOLD, 5'd3, 8});
    q.push_back('{RUN, 5'd3, 16});
    mon_en = 1'b1;
    rst_n = 1'b1;
    wait_idle(80, "run3");
    check("run3_rst", rst_ovr, 16'h0008);

    design_sel = 5'd7;
    repeat (3) @(negedge clk);
    design_sel = 5'd3;
    repeat (15) @(negedge clk);
    check("glitch_rst", rst_ovr, 16'h0008);
    check("glitch_state", dut.state, RUN);
    des_out[3*NP +: NP] = ~des_out[3*NP +: NP];
    #1;
    check("zero_lat", io_out, slice(des_out, 5'd3));
    @(negedge clk);

    q.push_back('{GUARD, 5'd5, 0});
    q.push_back('{HOLD, 5'd5, 8});
    q.push_back('{RUN, 5'd5, 16});
    design_sel = 5'd5;
    wait_idle(80, "run5");
    check("run5_rst", rst_ovr, 16'h0020);

    q.push_back('{GUARD, 5'd20, 0});
    q.push_back('{PARK, 5'd20, 8});
    design_sel = 5'd20;
    wait_idle(60, "park20");
    repeat (5) @(negedge clk);
    check("park_state", dut.state, PARK);
    check_phase(PARK, 5'd20, "park");

    q.push_back('{GUARD, 5'd5, 0});
    q.push_back('{HOLD, 5'd5, 8});
    design_sel = 5'd5;
    wait_idle(60, "hold5");
    q.push_back('{GUARD, 5'd2, 0});
    q.push_back('{HOLD, 5'd2, 8});
    q.push_back('{RUN, 5'd2, 16});
    design_sel = 5'd2;
    wait_idle(80, "run2");
    check("run2_rst", rst_ovr, 16'h0004);

    q.push_back('{GUARD, 5'd9, 0});
    design_sel = 5'd9;
    wait_idle(40, "guard9");
    q.push_back('{PARK, 5'h1f, 0});
    q.push_back('{GUARD, 5'd9, 0});
    q.push_back('{HOLD, 5'd9, 8});
    q.push_back('{RUN, 5'd9, 16});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_state", dut.state, PARK);
    check("rst_mid_cnt", dut.cnt, 0);
    check_phase(PARK, 5'h1f, "rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(80, "run9");
    check("run9_rst", rst_ovr, 16'h0200);

    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
